fifo_rd_stream: RTL

- Read-side drain engine for the synchronous FIFO. It issues rd_en into the FIFO read port and absorbs the FIFO's 1-cycle registered data_out latency in a small skid buffer.
- It presents the words downstream as a valid/ready stream.
- It sits between the FIFO DUT and any consumer, so the consumer never handles empty/underflow or read latency itself.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_rd_stream_if.sv | 48 ++++
 rtl/fifo_rd_stream_skid_buf.sv | 62 ++++++
 rtl/fifo_rd_stream.sv | 69 ++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO sizing and data word type, used by the FIFO, its read-side
// stream engine and the benches that drive them.
package fifo_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

  // Circular pointer increment for buffers whose depth need not be a power of two.
  function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Bundles the FIFO read port, the downstream valid/ready stream and the
// status outputs of fifo_rd_stream.
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int CNT_WIDTH = 16
);

  logic                 en;
  logic                 fifo_empty;
  fifo_word_t           fifo_data_out;
  logic                 fifo_underflow;
  logic                 fifo_rd_en;
  logic                 m_valid;
  logic                 m_ready;
  fifo_word_t           m_data;
  logic [CNT_WIDTH-1:0] rd_count;
  logic                 err_underflow;

  // The drain engine drives the FIFO read request and the stream.
  modport master (
    input  en,
    input  fifo_empty,
    input  fifo_data_out,
    input  fifo_underflow,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data,
    output rd_count,
    output err_underflow
  );

  // FIFO plus consumer side of the same bundle.
  modport slave (
    output en,
    output fifo_empty,
    output fifo_data_out,
    output fifo_underflow,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data,
    input  rd_count,
    input  err_underflow
  );

endinterface

// File: rtl/fifo_rd_stream_skid_buf.sv
// Small circular skid buffer that holds words returned by the FIFO until the
// downstream consumer accepts them; m_data is forced to zero while empty.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter  int BUF_DEPTH = 3,
  localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fifo_word_t       push_data,
  input  logic             ready,
  output logic [OCC_W-1:0] occ,
  output logic             valid,
  output logic             pop,
  output fifo_word_t       data
);

  fifo_word_t       mem [BUF_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return PTR_W'(ptr_wrap_inc(32'(p), BUF_DEPTH));
  endfunction

  // No bypass: a word pushed this cycle becomes visible only once occ counts it.
  assign valid = rst_n & (occ != '0);
  assign pop   = valid & ready;
  assign data  = valid ? mem[head] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      if (push) begin
        tail <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      // The issue logic reserves space before reading, so a push into a full buffer is a bug.
      assert (!(push && !pop && occ == OCC_W'(BUF_DEPTH)));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= push_data;
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: issues FIFO reads only when the skid buffer has room
// for every outstanding word, and presents the words as a valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int BUF_DEPTH = 3,
  parameter int CNT_WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  fifo_rd_stream_if.master bus
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  logic [OCC_W-1:0]     occ;
  logic                 inflight;
  logic                 space;
  logic                 rd_en;
  logic                 push;
  logic                 pop;
  logic                 m_valid;
  fifo_word_t           m_data;
  logic [CNT_WIDTH-1:0] rd_count;
  logic                 err_underflow;

  // Registered occupancy plus the outstanding read must leave a free slot;
  // m_ready is deliberately kept out of this path.
  assign space = (32'(occ) + 32'(inflight)) < 32'(BUF_DEPTH);
  assign rd_en = rst_n & bus.en & ~bus.fifo_empty & space;
  assign push  = inflight & ~bus.fifo_underflow;

  fifo_rd_skid_buf #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.fifo_data_out),
    .ready     (bus.m_ready),
    .occ       (occ),
    .valid     (m_valid),
    .pop       (pop),
    .data      (m_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      rd_count      <= '0;
      err_underflow <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (inflight && bus.fifo_underflow) begin
        err_underflow <= 1'b1;
      end
      if (pop) begin
        rd_count <= rd_count + 1'b1;
      end
    end
  end

  assign bus.fifo_rd_en    = rd_en;
  assign bus.m_valid       = m_valid;
  assign bus.m_data        = m_data;
  assign bus.rd_count      = rd_count;
  assign bus.err_underflow = err_underflow;

endmodule
